// File: rtl/csa_accum_seq.sv
// csa_accum_seq: multi-operand accumulator that keeps its running total in
// redundant sum/carry form through a 3:2 compressor and resolves it with a
// single carry-propagate add at the end of the job.
module csa_accum_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ACC_W = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [WIDTH-1:0] op_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [ACC_W-1:0] result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;

  logic [ACC_W-1:0]   s_vec_q, s_vec_d;
  logic [ACC_W-1:0]   c_vec_q, c_vec_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [ACC_W-1:0]   result_q, result_d;

  logic               op_ready_q, op_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               start_ok_c;
  logic               reject_c;
  logic               accept_c;
  logic               last_c;
  logic               res_hs_c;
  logic [ACC_W-1:0]   x_ext_c;
  logic [ACC_W-1:0]   csa_sum_c;
  logic [ACC_W-1:0]   csa_carry_c;

  // Job request qualification, operand and result handshakes
  always_comb begin
    start_ok_c = 1'b0;
    reject_c   = 1'b0;
    if (state_q == S_IDLE && start) begin
      if (num_ops >= CNT_W'(2)) begin
        start_ok_c = 1'b1;
      end else begin
        reject_c = 1'b1;
      end
    end
    accept_c = (state_q == S_ACCUM) && op_valid && op_ready_q;
    last_c   = (remaining_q == CNT_W'(1));
    res_hs_c = (state_q == S_DONE) && res_valid_q && res_ready;
  end

  // 3:2 compression of the running sum/carry pair with the incoming operand
  always_comb begin
    x_ext_c     = ACC_W'(op_data);
    csa_sum_c   = s_vec_q ^ c_vec_q ^ x_ext_c;
    csa_carry_c = ((s_vec_q & c_vec_q) | (s_vec_q & x_ext_c) | (c_vec_q & x_ext_c)) << 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_c) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept_c && last_c) begin
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_hs_c) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: clear on job start, compress on accept, resolve once
  always_comb begin
    s_vec_d     = s_vec_q;
    c_vec_d     = c_vec_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    if (start_ok_c) begin
      s_vec_d     = '0;
      c_vec_d     = '0;
      remaining_d = num_ops;
    end
    if (accept_c) begin
      s_vec_d     = csa_sum_c;
      c_vec_d     = csa_carry_c;
      remaining_d = remaining_q - CNT_W'(1);
    end
    if (state_q == S_RESOLVE) begin
      result_d = s_vec_q + c_vec_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vec_q     <= '0;
      c_vec_q     <= '0;
      remaining_q <= '0;
      result_q    <= '0;
    end else begin
      s_vec_q     <= s_vec_d;
      c_vec_q     <= c_vec_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
    end
  end

  // Output decode from the upcoming state so the flags are registered with it
  always_comb begin
    op_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;
    op_ready_d  = (state_d == S_ACCUM);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    err_d       = reject_c;
  end

  // Output flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csa_accum_seq.sv
// Bench for csa_accum_seq: scenario tasks with an expected-result queue.
module tb_csa_accum_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACC_W = WIDTH + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic [WIDTH-1:0] op_data;
  logic             op_valid;
  logic             op_ready;
  logic [ACC_W-1:0] result;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             err;

  int n_vec;
  int n_bad;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] exp_v;

  csa_accum_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .op_data   (op_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .result    (result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    num_ops = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_op(input logic [WIDTH-1:0] d);
    int cnt;
    cnt = 0;
    while (!op_ready) begin
      tick();
      cnt++;
      if (cnt > 100) begin
        $display("FAIL send_op_timeout: op_ready=%0b required 1", op_ready);
        $fatal(1);
      end
    end
    op_valid = 1'b1;
    op_data  = d;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_res();
    int cnt;
    cnt = 0;
    while (!res_valid) begin
      tick();
      cnt++;
      if (cnt > 200) begin
        $display("FAIL wait_res_timeout: res_valid=%0b required 1", res_valid);
        $fatal(1);
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({op_ready, res_valid, busy, err} !== 4'b0000 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rdy/val/busy/err=%b result=%h required 0000 / 0",
               {op_ready, res_valid, busy, err}, result);
    end
  endtask

  task automatic test_two_ops();
    do_start(CNT_W'(2));
    exp_q.push_back(ACC_W'(20'h10000));
    send_op(16'hFFFF);
    send_op(16'h0001);
    n_vec++;
    if (res_valid !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL two_ops_resolve: val=%b rdy=%b busy=%b required 0 0 1", res_valid, op_ready, busy);
    end
    tick();
    exp_v = exp_q.pop_front();
    n_vec++;
    if (res_valid !== 1'b1 || result !== exp_v || err !== 1'b0) begin
      n_bad++;
      $display("FAIL two_ops_result: val=%b result=%h err=%b required 1 %h 0", res_valid, result, err, exp_v);
    end
    handshake();
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL two_ops_release: val=%b busy=%b required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_full_count();
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    do_start(CNT_W'(15));
    exp_q.push_back(ACC_W'(20'hEFFF1));
    n_vec++;
    if (op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_first_ready: op_ready=%b required 1", op_ready);
    end
    op_valid = 1'b1;
    op_data  = 16'hFFFF;
    while (op_ready === 1'b1 && cyc < 40) begin
      acc++;
      tick();
      cyc++;
    end
    n_vec++;
    if (acc != 15) begin
      n_bad++;
      $display("FAIL full_accepts: accepted=%0d required 15", acc);
    end
    n_vec++;
    if (op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL full_resolve: rdy=%b val=%b busy=%b required 0 0 1", op_ready, res_valid, busy);
    end
    tick();
    exp_v = exp_q.pop_front();
    n_vec++;
    if (res_valid !== 1'b1 || op_ready !== 1'b0 || result !== exp_v) begin
      n_bad++;
      $display("FAIL full_result: val=%b rdy=%b result=%h required 1 0 %h", res_valid, op_ready, result, exp_v);
    end
    op_valid = 1'b0;
    handshake();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ops [4];
    ops[0] = 16'd3; ops[1] = 16'd5; ops[2] = 16'd7; ops[3] = 16'd9;
    do_start(CNT_W'(4));
    exp_q.push_back(ACC_W'(24));
    for (int i = 0; i < 4; i++) begin
      send_op(ops[i]);
      if (i < 3) begin
        tick();
        tick();
      end
    end
    wait_res();
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (res_valid !== 1'b1 || result !== exp_v || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: val=%b result=%h busy=%b required 1 %h 1", i, res_valid, result, busy, exp_v);
      end
      tick();
    end
    handshake();
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: val=%b busy=%b required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reject();
    for (int n = 0; n < 2; n++) begin
      do_start(CNT_W'(n));
      n_vec++;
      if (err !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_pulse[%0d]: err=%b busy=%b rdy=%b required 1 0 0", n, err, busy, op_ready);
      end
      tick();
      n_vec++;
      if (err !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_after[%0d]: err=%b busy=%b rdy=%b required 0 0 0", n, err, busy, op_ready);
      end
    end
  endtask

  task automatic test_start_while_busy();
    do_start(CNT_W'(3));
    exp_q.push_back(ACC_W'(6));
    send_op(16'd1);
    start   = 1'b1;
    num_ops = CNT_W'(2);
    tick();
    start   = 1'b0;
    send_op(16'd2);
    send_op(16'd3);
    wait_res();
    start   = 1'b1;
    num_ops = CNT_W'(5);
    tick();
    start   = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (res_valid !== 1'b1 || result !== exp_v || err !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_result: val=%b result=%h err=%b required 1 %h 0", res_valid, result, err, exp_v);
    end
    handshake();
    tick();
    n_vec++;
    if (busy !== 1'b0 || op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_nojob: busy=%b rdy=%b required 0 0", busy, op_ready);
    end
  endtask

  task automatic test_reset_mid_job();
    do_start(CNT_W'(5));
    send_op(16'd10);
    send_op(16'd20);
    send_op(16'd30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({op_ready, res_valid, busy, err} !== 4'b0000 || result !== '0) begin
      n_bad++;
      $display("FAIL midjob_reset: rdy/val/busy/err=%b result=%h required 0000 / 0",
               {op_ready, res_valid, busy, err}, result);
    end
    do_start(CNT_W'(3));
    exp_q.push_back(ACC_W'(6));
    send_op(16'd1);
    send_op(16'd2);
    send_op(16'd3);
    wait_res();
    exp_v = exp_q.pop_front();
    n_vec++;
    if (result !== exp_v) begin
      n_bad++;
      $display("FAIL midjob_followup: result=%h required %h", result, exp_v);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    int unsigned sum;
    logic [WIDTH-1:0] d;
    for (int j = 0; j < 4; j++) begin
      n   = $urandom_range(2, 15);
      sum = 0;
      do_start(CNT_W'(n));
      for (int k = 0; k < int'(n); k++) begin
        d   = WIDTH'($urandom_range(0, 65535));
        sum = sum + int'(d);
        send_op(d);
      end
      exp_q.push_back(ACC_W'(sum));
      n_vec++;
      if (res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_early[%0d]: val=%b required 0", j, res_valid);
      end
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (res_valid !== 1'b1 || result !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_result[%0d]: val=%b result=%h required 1 %h", j, res_valid, result, exp_v);
      end
      handshake();
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_ops   = '0;
    op_data   = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_two_ops();
    test_full_count();
    test_backpressure();
    test_reject();
    test_start_while_busy();
    test_reset_mid_job();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
